// File: rtl/mc_main_controller.sv
// Multicycle RV32 main controller: Moore FSM sequencing fetch/decode/execute/writeback.
// State-decoded outputs are registered from the state being entered; a few enables also gate on inputs.
module mc_main_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_res,
    output logic [1:0] alu_op,
    output logic       branch,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    // state     | meaning
    // FETCH     | read instruction at PC, PC+4 into PC when memory answers
    // DECODE    | register read, branch/JAL target into ALUOut
    // MEM_ADR   | load/store address = rs1 + imm
    // MEM_READ  | load data access, waits for mem_ready
    // MEM_WB    | load data into rd
    // MEM_WRITE | store access, waits for mem_ready
    // EXEC_R    | register-register ALU op
    // EXEC_I    | register-immediate ALU op
    // ALU_WB    | ALUOut into rd
    // BRANCH    | compare rs1/rs2, load PC from ALUOut if taken
    // JAL       | PC <= target, ALUOut <= oldPC+4
    // JALR      | target = rs1 + imm into ALUOut
    // LUI       | 0 + U-immediate
    // ILLEGAL   | unknown opcode, parked until reset
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t cur_state;
    state_t next_state;
    state_t enter_state;
    logic   done_r;

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_FETCH:     if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_BR:             next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR:   next_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
            S_EXEC_R:    next_state = S_ALU_WB;
            S_EXEC_I:    next_state = S_ALU_WB;
            S_LUI:       next_state = S_ALU_WB;
            S_ALU_WB:    next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_JALR:      next_state = S_JAL;
            S_JAL:       next_state = S_ALU_WB;
            S_ILLEGAL:   next_state = S_ILLEGAL;
            default:     next_state = S_ILLEGAL;
        endcase
    end

    assign enter_state = rst ? S_FETCH : next_state;

    // Outputs are decoded from the state about to be entered so they line up with cur_state.
    always_ff @(posedge clk) begin
        cur_state  <= enter_state;
        alu_op     <= 2'b00;
        branch     <= 1'b0;
        adr_src    <= 1'b0;
        mem_write  <= 1'b0;
        reg_write  <= 1'b0;
        result_src <= 2'b00;
        alu_src_a  <= 2'b00;
        alu_src_b  <= 2'b00;
        illegal    <= 1'b0;
        done_r     <= 1'b0;
        case (enter_state)
            S_FETCH: begin
                alu_src_b  <= 2'b10;
                result_src <= 2'b10;
            end
            S_DECODE: begin
                alu_src_a <= 2'b01;
                alu_src_b <= 2'b01;
            end
            S_MEM_ADR: begin
                alu_src_a <= 2'b10;
                alu_src_b <= 2'b01;
            end
            S_MEM_READ:  adr_src <= 1'b1;
            S_MEM_WB: begin
                result_src <= 2'b01;
                reg_write  <= 1'b1;
                done_r     <= 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src   <= 1'b1;
                mem_write <= 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a <= 2'b10;
                alu_op    <= 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a <= 2'b10;
                alu_src_b <= 2'b01;
                alu_op    <= 2'b11;
            end
            S_LUI: begin
                alu_src_a <= 2'b11;
                alu_src_b <= 2'b01;
            end
            S_ALU_WB: begin
                reg_write <= 1'b1;
                done_r    <= 1'b1;
            end
            S_BRANCH: begin
                alu_src_a <= 2'b10;
                alu_op    <= 2'b01;
                branch    <= 1'b1;
                done_r    <= 1'b1;
            end
            S_JALR: begin
                alu_src_a <= 2'b10;
                alu_src_b <= 2'b01;
            end
            S_JAL: begin
                alu_src_a <= 2'b01;
                alu_src_b <= 2'b10;
            end
            S_ILLEGAL:   illegal <= 1'b1;
            default:     illegal <= 1'b1;
        endcase
    end

    // Handshake-dependent enables; branch_res only matters while evaluating a branch.
    assign ir_write   = (cur_state == S_FETCH) && mem_ready;
    assign pc_write   = ((cur_state == S_FETCH) && mem_ready) || (cur_state == S_JAL)
                        || ((cur_state == S_BRANCH) && branch_res);
    assign instr_done = done_r || ((cur_state == S_MEM_WRITE) && mem_ready);
    assign state      = cur_state;

    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            OP_STORE:          imm_src = 3'b001;
            OP_BR:             imm_src = 3'b010;
            OP_JAL:            imm_src = 3'b011;
            OP_LUI, OP_AUIPC:  imm_src = 3'b100;
            default:           imm_src = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_mc_main_controller.sv
// Scoreboard bench for mc_main_controller: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares against the DUT.
module tb_mc_main_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_res;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    mc_main_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_res(branch_res),
        .alu_op(alu_op), .branch(branch), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .state(state), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] BAD  = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] alu_op;
        logic       branch;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic       illegal;
        logic       done;
    } vec_t;

    vec_t exp_q[$];
    int   tag_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_no   = 0;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            SW:      return 3'b001;
            BEQ:     return 3'b010;
            JAL:     return 3'b011;
            LUI:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Expected output table, written from the state descriptions.
    function automatic vec_t expect_out(input logic [3:0] st, input logic mr, input logic br,
                                        input logic [6:0] op);
        vec_t v;
        v = '0;
        v.st  = st;
        v.imm = imm_of(op);
        case (st)
            4'd0:  begin v.b = 2'b10; v.result_src = 2'b10; v.ir_write = mr; v.pc_write = mr; end
            4'd1:  begin v.a = 2'b01; v.b = 2'b01; end
            4'd2:  begin v.a = 2'b10; v.b = 2'b01; end
            4'd3:  v.adr_src = 1'b1;
            4'd4:  begin v.result_src = 2'b01; v.reg_write = 1'b1; v.done = 1'b1; end
            4'd5:  begin v.adr_src = 1'b1; v.mem_write = 1'b1; v.done = mr; end
            4'd6:  begin v.a = 2'b10; v.b = 2'b00; v.alu_op = 2'b10; end
            4'd7:  begin v.a = 2'b10; v.b = 2'b01; v.alu_op = 2'b11; end
            4'd8:  begin v.reg_write = 1'b1; v.done = 1'b1; end
            4'd9:  begin v.a = 2'b10; v.alu_op = 2'b01; v.branch = 1'b1; v.done = 1'b1;
                         v.pc_write = br; end
            4'd10: begin v.a = 2'b01; v.b = 2'b10; v.pc_write = 1'b1; end
            4'd11: begin v.a = 2'b10; v.b = 2'b01; end
            4'd12: begin v.a = 2'b11; v.b = 2'b01; end
            default: v.illegal = 1'b1;
        endcase
        return v;
    endfunction

    // One cycle: drive inputs, record what the current state must present, advance.
    task automatic step(input logic r, input logic [6:0] op, input logic mr, input logic br,
                        input logic [3:0] exp_st);
        rst        = r;
        opcode     = op;
        mem_ready  = mr;
        branch_res = br;
        exp_q.push_back(expect_out(exp_st, mr, br, op));
        tag_q.push_back(vec_no);
        vec_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        vec_t act;
        vec_t exp;
        int   tag;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                act = {state, alu_op, branch, pc_write, adr_src, mem_write, ir_write, reg_write,
                       result_src, alu_src_a, alu_src_b, imm_src, illegal, instr_done};
                n_checks++;
                if (act === exp) n_pass++;
                else $display("FAIL vec%0d state/outputs: got %h expected %h", tag, act, exp);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = ADD; mem_ready = 1'b0; branch_res = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state with memory idle: FETCH decode, no writes
        step(0, ADD, 0, 0, 4'd0);
        step(0, ADD, 0, 1, 4'd0);
        // add, branch_res ignored outside BRANCH
        step(0, ADD, 1, 0, 4'd0);
        step(0, ADD, 1, 1, 4'd1);
        step(0, ADD, 1, 0, 4'd6);
        step(0, ADD, 1, 1, 4'd8);
        // lw with three wait cycles
        step(0, LW, 1, 0, 4'd0);
        step(0, LW, 1, 0, 4'd1);
        step(0, LW, 1, 0, 4'd2);
        step(0, LW, 0, 0, 4'd3);
        step(0, LW, 0, 0, 4'd3);
        step(0, LW, 0, 0, 4'd3);
        step(0, LW, 1, 0, 4'd3);
        step(0, LW, 1, 0, 4'd4);
        // sw with one wait cycle
        step(0, SW, 1, 0, 4'd0);
        step(0, SW, 1, 0, 4'd1);
        step(0, SW, 1, 0, 4'd2);
        step(0, SW, 0, 0, 4'd5);
        step(0, SW, 1, 0, 4'd5);
        // beq taken, then not taken
        step(0, BEQ, 1, 0, 4'd0);
        step(0, BEQ, 1, 1, 4'd1);
        step(0, BEQ, 1, 1, 4'd9);
        step(0, BEQ, 1, 0, 4'd0);
        step(0, BEQ, 1, 0, 4'd1);
        step(0, BEQ, 1, 0, 4'd9);
        // jal, jalr, lui, addi
        step(0, JAL, 1, 0, 4'd0);
        step(0, JAL, 1, 0, 4'd1);
        step(0, JAL, 1, 0, 4'd10);
        step(0, JAL, 1, 1, 4'd8);
        step(0, JALR, 1, 0, 4'd0);
        step(0, JALR, 1, 0, 4'd1);
        step(0, JALR, 1, 0, 4'd11);
        step(0, JALR, 1, 0, 4'd10);
        step(0, JALR, 1, 0, 4'd8);
        step(0, LUI, 1, 0, 4'd0);
        step(0, LUI, 1, 0, 4'd1);
        step(0, LUI, 1, 0, 4'd12);
        step(0, LUI, 1, 0, 4'd8);
        step(0, ADDI, 1, 0, 4'd0);
        step(0, ADDI, 1, 0, 4'd1);
        step(0, ADDI, 1, 0, 4'd7);
        step(0, ADDI, 1, 0, 4'd8);
        // illegal opcode is sticky until reset
        step(0, BAD, 1, 0, 4'd0);
        step(0, BAD, 1, 1, 4'd1);
        for (int i = 0; i < 10; i++) step(0, BAD, 1, 1, 4'd15);
        step(1, BAD, 1, 1, 4'd15);
        step(0, SW, 0, 0, 4'd0);
        // reset while a store is stalled
        step(0, SW, 1, 0, 4'd0);
        step(0, SW, 1, 0, 4'd1);
        step(0, SW, 1, 0, 4'd2);
        step(0, SW, 0, 0, 4'd5);
        step(1, SW, 0, 0, 4'd5);
        step(0, SW, 0, 0, 4'd0);
        // reset while a load is stalled
        step(0, LW, 1, 0, 4'd0);
        step(0, LW, 1, 0, 4'd1);
        step(0, LW, 1, 0, 4'd2);
        step(1, LW, 0, 0, 4'd3);
        step(0, LW, 0, 0, 4'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
            n_checks += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_main_controller.md
MC_MAIN_CONTROLLER -- requirements
Module: mc_main_controller

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-003 opcode  in  7  instr[6:0] from instruction register; valid from DECODE onward.
REQ-004 mem_ready  in  1  memory handshake; access completes on an edge where it is 1.
REQ-005 branch_res  in  1  taken-branch flag from the ALU controller (branch & condition).
REQ-006 alu_op  out  2  R=10, I=11, add=00, sub/compare=01; feeds the ALU controller.
REQ-007 branch  out  1  branch-evaluation enable to the ALU controller.
REQ-008 pc_write  out  1  PC load enable, = pc_update | branch_res.
REQ-009 adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_write, ir_write, reg_write  out  1 each  memory, IR and register-file write enables.
REQ-011 result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result.
REQ-012 alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
REQ-013 alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
REQ-014 imm_src  out  3  I=000, S=001, B=010, J=011, U=100, other=000; combinational from opcode.
REQ-015 state  out  4  current state code; instr_done out 1; illegal out 1.

Function
REQ-016 Moore FSM; outputs SHALL decode from state only, except ir_write, pc_update, pc_write and instr_done, which SHALL also gate on inputs as listed below.
REQ-017 State codes SHALL be: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, ILLEGAL=15.
REQ-018 Any output not listed for a state SHALL be 0.
REQ-019 FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready; go to DECODE when mem_ready=1, else hold FETCH.
REQ-020 DECODE: a=01, b=01, alu_op=00 (branch/JAL target into ALUOut).
REQ-021 DECODE next state by opcode: 0000011 or 0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; any other -> ILLEGAL.
REQ-022 MEM_ADR: a=10, b=01, alu_op=00; opcode 0000011 -> MEM_READ, otherwise -> MEM_WRITE.
REQ-023 MEM_READ: adr_src=1; hold until mem_ready=1, then -> MEM_WB.
REQ-024 MEM_WB: result_src=01, reg_write=1, instr_done=1; -> FETCH.
REQ-025 MEM_WRITE: adr_src=1, mem_write=1 held every cycle until mem_ready=1; on that edge -> FETCH with instr_done=1.
REQ-026 EXEC_R: a=10, b=00, alu_op=10 -> ALU_WB.
REQ-027 EXEC_I: a=10, b=01, alu_op=11 -> ALU_WB.
REQ-028 LUI: a=11, b=01, alu_op=00 -> ALU_WB.
REQ-029 ALU_WB: result_src=00, reg_write=1, instr_done=1; -> FETCH.
REQ-030 BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1, instr_done=1; pc_write=branch_res in this state only; -> FETCH.
REQ-031 JALR: a=10, b=01, alu_op=00 (target into ALUOut) -> JAL.
REQ-032 JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALU_WB (rd <= oldPC+4).
REQ-033 ILLEGAL: illegal=1; sticky until rst, with no writes of any kind.
REQ-034 branch_res SHALL be ignored in every state except BRANCH.
REQ-035 Cycle counts with mem_ready tied to 1: R/I/LUI = 4, lw = 5, sw = 4, beq = 3, jal = 4, jalr = 5.

Reset
REQ-036 An edge with rst=1 SHALL force state to FETCH from any state, including mid-wait and ILLEGAL; rst has priority over all transitions.
REQ-037 After reset, outputs SHALL equal FETCH decode; with mem_ready=0, all write enables and instr_done SHALL be 0.

Verification
REQ-038 add (opcode 0110011), mem_ready=1: states 0,1,6,8; alu_op=10 in EXEC_R; reg_write=1 only in ALU_WB.
REQ-039 lw with mem_ready low for 3 cycles in MEM_READ: state holds 3 for 3 extra cycles, then 4; reg_write is a single cycle with result_src=01.
REQ-040 beq in BRANCH with branch_res=1 -> pc_write=1, branch=1, alu_op=01; with branch_res=0 -> pc_write=0; branch_res=1 during ALU_WB -> pc_write=0.
REQ-041 jalr: states 0,1,11,10,8; pc_write=1 in JAL; reg_write=1 with result_src=00 in ALU_WB.
REQ-042 opcode 1111111 -> state 15, illegal=1 held for 10 cycles with no writes; rst=1 -> state 0.
REQ-043 rst pulsed while in MEM_WRITE with mem_ready=0 -> next state 0; mem_write=0 from that cycle.
